// File: rtl/cga_mode_if.sv
// CPU-side mode-change handshake (4-phase req/ack) for the CGA sequencer.
interface cga_mode_if;
   logic mode_req;
   logic mode_composite;
   logic mode_hires;
   logic mode_ack;

   modport master (
      output mode_req,
      output mode_composite,
      output mode_hires,
      input  mode_ack
   );

   modport slave (
      input  mode_req,
      input  mode_composite,
      input  mode_hires,
      output mode_ack
   );
endinterface

// File: rtl/cga_video_sequencer.sv
// CGA VGA-port timing and mode controller: clkdiv, hcount, pix_load, line_start.
// CGA_VSYNC_APPLY_EN: mode changes apply on vsync rise instead of hsync rise.
module cga_video_sequencer #(
   parameter int DIV_WIDTH    = 5,
   parameter int HCOUNT_WIDTH = 11
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    hsync,
   input  logic                    vsync,
   cga_mode_if.slave               mode,
   output logic [DIV_WIDTH-1:0]    clkdiv,
   output logic [HCOUNT_WIDTH-1:0] hcount,
   output logic [2:0]              burst_phase,
   output logic                    composite,
   output logic                    hires,
   output logic                    pix_load,
   output logic                    line_start
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic hsync_d;
   logic hs_rise;
   logic hs_fall;
   logic apply_edge;
   logic latch_en;
   logic apply_en;
   logic pend_comp;
   logic pend_hires;

   assign hs_rise = hsync & ~hsync_d;
   assign hs_fall = ~hsync & hsync_d;

`ifdef CGA_VSYNC_APPLY_EN
   logic vsync_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vsync_d <= 1'b0;
      end else begin
         vsync_d <= vsync;
      end
   end

   assign apply_edge = vsync & ~vsync_d;
`else
   logic unused_vsync;

   assign unused_vsync = vsync;
   assign apply_edge   = hs_rise;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (mode.mode_req) state_nxt = WAIT;
         WAIT: if (apply_edge)    state_nxt = HOLD;
         HOLD: if (!mode.mode_req) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Once accepted, a request is committed even if req drops in WAIT.
   always_comb begin
      latch_en      = 1'b0;
      apply_en      = 1'b0;
      mode.mode_ack = 1'b0;
      unique case (state)
         IDLE: latch_en = mode.mode_req;
         WAIT: apply_en = apply_edge;
         HOLD: mode.mode_ack = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hsync_d    <= 1'b0;
         clkdiv     <= '0;
         hcount     <= '0;
         line_start <= 1'b0;
         composite  <= 1'b0;
         hires      <= 1'b0;
         pend_comp  <= 1'b0;
         pend_hires <= 1'b0;
      end else begin
         hsync_d    <= hsync;
         line_start <= hs_fall;
         if (hsync) begin
            hcount <= '0;
         end else if (hcount != '1) begin
            hcount <= hcount + 1'b1;
         end
         if (latch_en) begin
            pend_comp  <= mode.mode_composite;
            pend_hires <= mode.mode_hires;
         end
         // Realign pixel phase to the new mode.
         if (apply_en) begin
            clkdiv    <= '0;
            composite <= pend_comp;
            hires     <= pend_hires;
         end else begin
            clkdiv <= clkdiv + 1'b1;
         end
      end
   end

   assign burst_phase = hcount[2:0];
   assign pix_load    = hires ? (clkdiv[1:0] == 2'b11)
                              : (clkdiv[2:0] == 3'b111);

endmodule
